// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared constants and FSM encoding for the RV32 pipeline controller
package riscv_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b10;
  localparam logic [1:0] PC_SEL_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_ERROR    = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - datapath <-> controller signal bundle
interface pipeline_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  instr_x;
  logic             valid_x;
  logic             br_taken_x;
  logic [4:0]       rd_w;
  logic             regwrite_w;
  logic             dmem_req_w;
  logic             dmem_ready;
  logic             imem_ready;
  logic [1:0]       pc_sel;
  logic             stall_f;
  logic             stall_x;
  logic             stall_w;
  logic             flush_x;
  logic             fwd_a;
  logic             fwd_b;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  instr_x, valid_x, br_taken_x, rd_w, regwrite_w, dmem_req_w, dmem_ready, imem_ready,
    output pc_sel, stall_f, stall_x, stall_w, flush_x, fwd_a, fwd_b, halted, mem_err,
           cycle_cnt, instret_cnt
  );

  modport slave (
    output instr_x, valid_x, br_taken_x, rd_w, regwrite_w, dmem_req_w, dmem_ready, imem_ready,
    input  pc_sel, stall_f, stall_x, stall_w, flush_x, fwd_a, fwd_b, halted, mem_err,
           cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_perf_counters.sv
// rtl/pipeline_ctrl_perf_counters.sv - free-running cycle and retired-instruction counters
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cycle_en,
  input  logic             instret_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cycle_en)   cycle_cnt   <= cycle_cnt + 1'b1;
      if (instret_en) instret_cnt <= instret_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/stall/redirect sequencer for the 3-stage RV32 core
module pipeline_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN        = riscv_ctrl_pkg::XLEN,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic             clk,
  input logic             reset,
  pipeline_ctrl_if.master bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [6:0]        opcode;
  logic              jump;
  logic              branch;
  logic              ecall;
  logic              memstall;
  logic              active;
  logic [1:0]        pc_sel_c;
  logic              stall_f_c;
  logic              stall_x_c;
  logic              stall_w_c;
  logic              flush_x_c;
  logic              cycle_en;
  logic              instret_en;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  instret_q;

  assign opcode = bus.instr_x[6:0];
  assign jump   = bus.valid_x & ((opcode == OP_JAL) | (opcode == OP_JALR));
  assign branch = bus.valid_x & (opcode == OP_BRANCH) & bus.br_taken_x;
  assign ecall  = bus.valid_x & (opcode == OP_SYSTEM) & (bus.instr_x == XLEN'(ECALL_INSTR));

  assign memstall = ((state == ST_RUN) & bus.dmem_req_w & !bus.dmem_ready) |
                    ((state == ST_MEM_WAIT) & !bus.dmem_ready);

  // The cycle in which a wait completes behaves like a normal RUN cycle for X.
  assign active = ((state == ST_RUN) | (state == ST_MEM_WAIT)) & !memstall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (memstall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else if (ecall) begin
            state <= ST_HALT;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state    <= ecall ? ST_HALT : ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  always_comb begin
    pc_sel_c  = PC_SEL_PLUS4;
    stall_f_c = 1'b0;
    stall_x_c = 1'b0;
    stall_w_c = 1'b0;
    flush_x_c = 1'b0;
    if (!reset) begin
      pc_sel_c  = PC_SEL_HOLD;
      stall_f_c = 1'b1;
      flush_x_c = 1'b1;
    end else if ((state == ST_HALT) | (state == ST_ERROR)) begin
      pc_sel_c  = PC_SEL_HOLD;
      stall_f_c = 1'b1;
      stall_x_c = 1'b1;
      stall_w_c = 1'b1;
      flush_x_c = 1'b1;
    end else if (memstall) begin
      pc_sel_c  = PC_SEL_HOLD;
      stall_f_c = 1'b1;
      stall_x_c = 1'b1;
      stall_w_c = 1'b1;
    end else if (jump) begin
      pc_sel_c  = PC_SEL_JUMP;
      flush_x_c = 1'b1;
    end else if (branch) begin
      pc_sel_c  = PC_SEL_BRANCH;
      flush_x_c = 1'b1;
    end else if (!bus.imem_ready) begin
      // F waits for the fetch; X gets a bubble while W keeps draining.
      pc_sel_c  = PC_SEL_HOLD;
      stall_f_c = 1'b1;
      flush_x_c = 1'b1;
    end
  end

  assign bus.pc_sel  = pc_sel_c;
  assign bus.stall_f = stall_f_c;
  assign bus.stall_x = stall_x_c;
  assign bus.stall_w = stall_w_c;
  assign bus.flush_x = flush_x_c;

  assign bus.fwd_a = bus.regwrite_w & (bus.rd_w != 5'd0) & (bus.rd_w == bus.instr_x[19:15]);
  assign bus.fwd_b = bus.regwrite_w & (bus.rd_w != 5'd0) & (bus.rd_w == bus.instr_x[24:20]);

  assign bus.halted  = reset & (state == ST_HALT);
  assign bus.mem_err = reset & (state == ST_ERROR);

  assign cycle_en   = (state == ST_RUN) | (state == ST_MEM_WAIT);
  assign instret_en = active & bus.valid_x & !stall_x_c;

  perf_counters #(.CNT_W(CNT_W)) u_perf_counters (
    .clk         (clk),
    .reset       (reset),
    .cycle_en    (cycle_en),
    .instret_en  (instret_en),
    .cycle_cnt   (cycle_q),
    .instret_cnt (instret_q)
  );

  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_cyc;
  int   exp_ret;

  pipeline_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();

  pipeline_ctrl #(.XLEN(32), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        br;
    logic [4:0]  rd;
    logic        rw;
    logic        req;
    logic        rdy;
    logic        irdy;
    logic [1:0]  pc;
    logic        sf;
    logic        sx;
    logic        sw;
    logic        fl;
    logic        fa;
    logic        fb;
  } vec_t;

  localparam logic [31:0] I_ADD_5_0  = 32'h0002_81B3;
  localparam logic [31:0] I_ADD_0_0  = 32'h0000_01B3;
  localparam logic [31:0] I_ADD_5_6  = 32'h0062_81B3;
  localparam logic [31:0] I_ADD_5_5  = 32'h0052_81B3;
  localparam logic [31:0] I_BEQ      = 32'h0020_8463;
  localparam logic [31:0] I_JAL      = 32'h0080_00EF;
  localparam logic [31:0] I_JALR     = 32'h0000_8067;
  localparam logic [31:0] I_ECALL    = 32'h0000_0073;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int cyc_inc, input int ret_inc);
    @(posedge clk);
    #1;
    exp_cyc += cyc_inc;
    exp_ret += ret_inc;
  endtask

  task automatic idle_inputs();
    bus.instr_x    = I_ADD_0_0;
    bus.valid_x    = 1'b0;
    bus.br_taken_x = 1'b0;
    bus.rd_w       = 5'd0;
    bus.regwrite_w = 1'b0;
    bus.dmem_req_w = 1'b0;
    bus.dmem_ready = 1'b1;
    bus.imem_ready = 1'b1;
  endtask

  task automatic chk_stall_all(input string tag, input logic [1:0] pc, input logic s, input logic fl);
    chk({tag, "_pc_sel"},  32'(bus.pc_sel),  32'(pc));
    chk({tag, "_stall_f"}, 32'(bus.stall_f), 32'(s));
    chk({tag, "_stall_x"}, 32'(bus.stall_x), 32'(s));
    chk({tag, "_stall_w"}, 32'(bus.stall_w), 32'(s));
    chk({tag, "_flush_x"}, 32'(bus.flush_x), 32'(fl));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cyc  = 0;
    exp_ret  = 0;

    //          instr      v   br  rd  rw  req rdy ir  pc     sf  sx  sw  fl  fa  fb
    vecs[0]  = '{I_ADD_5_0, 1, 0, 0,  0, 0,  1,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{I_BEQ,     1, 1, 0,  0, 0,  1,  1, 2'b10, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{I_BEQ,     1, 0, 0,  0, 0,  1,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{I_BEQ,     0, 1, 0,  0, 0,  1,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{I_JAL,     1, 0, 0,  0, 0,  1,  1, 2'b01, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{I_JALR,    1, 0, 0,  0, 0,  1,  1, 2'b01, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{I_JAL,     1, 0, 0,  0, 0,  1,  0, 2'b01, 0, 0, 0, 1, 0, 0};
    vecs[7]  = '{I_BEQ,     1, 1, 0,  0, 0,  1,  0, 2'b10, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{I_ADD_5_0, 1, 0, 0,  0, 0,  1,  0, 2'b11, 1, 0, 0, 1, 0, 0};
    vecs[9]  = '{I_ADD_5_0, 1, 0, 5,  1, 0,  1,  1, 2'b00, 0, 0, 0, 0, 1, 0};
    vecs[10] = '{I_ADD_0_0, 1, 0, 0,  1, 0,  1,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{I_ADD_5_0, 1, 0, 0,  1, 0,  1,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{I_ADD_5_6, 1, 0, 6,  1, 0,  1,  1, 2'b00, 0, 0, 0, 0, 0, 1};
    vecs[13] = '{I_ADD_5_5, 1, 0, 5,  0, 0,  1,  1, 2'b00, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{I_ADD_5_5, 1, 0, 5,  1, 0,  1,  1, 2'b00, 0, 0, 0, 0, 1, 1};
    vecs[15] = '{I_ADD_5_5, 0, 0, 5,  1, 0,  1,  1, 2'b00, 0, 0, 0, 0, 1, 1};
    vecs[16] = '{I_ADD_5_0, 1, 0, 0,  0, 1,  1,  1, 2'b00, 0, 0, 0, 0, 0, 0};

    // Reset held for three edges
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_sel",  32'(bus.pc_sel),  32'(2'b11));
    chk("rst_stall_f", 32'(bus.stall_f), 32'd1);
    chk("rst_flush_x", 32'(bus.flush_x), 32'd1);
    reset = 1'b1;
    #4;
    chk("run0_cycle",   bus.cycle_cnt,   32'd0);
    chk("run0_instret", bus.instret_cnt, 32'd0);
    chk("run0_pc_sel",  32'(bus.pc_sel), 32'(2'b00));
    chk("run0_halted",  32'(bus.halted), 32'd0);
    step(1, 0);
    chk("run1_cycle", bus.cycle_cnt, 32'(exp_cyc));

    // Table of single-cycle RUN-state vectors
    for (int i = 0; i < 17; i++) begin
      bus.instr_x    = vecs[i].instr;
      bus.valid_x    = vecs[i].valid;
      bus.br_taken_x = vecs[i].br;
      bus.rd_w       = vecs[i].rd;
      bus.regwrite_w = vecs[i].rw;
      bus.dmem_req_w = vecs[i].req;
      bus.dmem_ready = vecs[i].rdy;
      bus.imem_ready = vecs[i].irdy;
      #4;
      chk($sformatf("vec%0d_pc_sel", i),  32'(bus.pc_sel),  32'(vecs[i].pc));
      chk($sformatf("vec%0d_stall_f", i), 32'(bus.stall_f), 32'(vecs[i].sf));
      chk($sformatf("vec%0d_stall_x", i), 32'(bus.stall_x), 32'(vecs[i].sx));
      chk($sformatf("vec%0d_stall_w", i), 32'(bus.stall_w), 32'(vecs[i].sw));
      chk($sformatf("vec%0d_flush_x", i), 32'(bus.flush_x), 32'(vecs[i].fl));
      chk($sformatf("vec%0d_fwd_a", i),   32'(bus.fwd_a),   32'(vecs[i].fa));
      chk($sformatf("vec%0d_fwd_b", i),   32'(bus.fwd_b),   32'(vecs[i].fb));
      step(1, int'(vecs[i].valid));
    end
    idle_inputs();
    chk("table_cycle",   bus.cycle_cnt,   32'(exp_cyc));
    chk("table_instret", bus.instret_cnt, 32'(exp_ret));

    // Three dmem wait cycles with a JAL parked in X
    bus.instr_x    = I_JAL;
    bus.valid_x    = 1'b1;
    bus.dmem_req_w = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk_stall_all($sformatf("memw%0d", i), 2'b11, 1'b1, 1'b0);
      step(1, 0);
    end
    bus.dmem_ready = 1'b1;
    #4;
    chk_stall_all("memw_ready", 2'b01, 1'b0, 1'b1);
    step(1, 1);
    idle_inputs();
    chk("memw_cycle",   bus.cycle_cnt,   32'(exp_cyc));
    chk("memw_instret", bus.instret_cnt, 32'(exp_ret));

    // Dmem never answers: trap after the 16th stalled cycle
    bus.dmem_req_w = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #4;
      chk($sformatf("tmo%0d_mem_err", i), 32'(bus.mem_err), 32'd0);
      chk($sformatf("tmo%0d_stall_w", i), 32'(bus.stall_w), 32'd1);
      step(1, 0);
    end
    chk("tmo_mem_err", 32'(bus.mem_err), 32'd1);
    bus.dmem_req_w = 1'b0;
    bus.dmem_ready = 1'b1;
    bus.valid_x    = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("err_mem_err", 32'(bus.mem_err), 32'd1);
    chk_stall_all("err", 2'b11, 1'b1, 1'b1);
    chk("err_cycle",   bus.cycle_cnt,   32'(exp_cyc));
    chk("err_instret", bus.instret_cnt, 32'(exp_ret));

    reset = 1'b0;
    step(0, 0);
    exp_cyc = 0;
    exp_ret = 0;
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("err_exit_mem_err", 32'(bus.mem_err), 32'd0);
    chk("err_exit_pc_sel",  32'(bus.pc_sel),  32'(2'b00));
    chk("err_exit_cycle",   bus.cycle_cnt,    32'd0);

    // ECALL retires, then the core halts and freezes
    bus.instr_x = I_ECALL;
    bus.valid_x = 1'b1;
    #3;
    chk("ecall_pc_sel", 32'(bus.pc_sel), 32'(2'b00));
    chk("ecall_halted", 32'(bus.halted), 32'd0);
    step(1, 1);
    chk("halt_instret", bus.instret_cnt, 32'(exp_ret));
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("halt%0d_halted", i), 32'(bus.halted), 32'd1);
      chk_stall_all($sformatf("halt%0d", i), 2'b11, 1'b1, 1'b1);
      chk($sformatf("halt%0d_cycle", i),   bus.cycle_cnt,   32'(exp_cyc));
      chk($sformatf("halt%0d_instret", i), bus.instret_cnt, 32'(exp_ret));
      step(0, 0);
    end

    reset = 1'b0;
    step(0, 0);
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("halt_exit_halted", 32'(bus.halted), 32'd0);
    chk("halt_exit_pc_sel", 32'(bus.pc_sel), 32'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
